fsm_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one downstream resource (e.g. a pulse/edge FSM

---
 rtl/fsm_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_fsm_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter: Moore FSM (IDLE/GRANT/GAP) with registered one-hot grants.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD grant-revocation counter.
module fsm_rr_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned ID_W     = 2
) (
   input  logic             i_sys_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_grant,
   output logic             o_grant_valid,
   output logic [ID_W-1:0]  o_grant_id,
   output logic             o_timeout
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             valid_q, valid_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  owner_next;
   logic             any_req, hi_found;
   logic [ID_W-1:0]  lo_idx, hi_idx, sel_idx;
   logic             hold_expired;

   if (N_REQ < 2 || ID_W != $clog2(N_REQ) || MAX_HOLD < 1) begin : g_param_check
      $error("fsm_rr_arbiter: invalid N_REQ/ID_W/MAX_HOLD combination");
   end

   // Lowest requester at or above the pointer wins, else the lowest overall (wrap).
   always_comb begin
      any_req  = 1'b0;
      hi_found = 1'b0;
      lo_idx   = '0;
      hi_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            any_req = 1'b1;
            lo_idx  = ID_W'(i);
            if (ID_W'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(i);
            end
         end
      end
      sel_idx = hi_found ? hi_idx : lo_idx;
   end

   assign owner_next = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      valid_d = valid_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d          = StGrant;
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               valid_d          = 1'b1;
               id_d             = sel_idx;
            end
         end
         StGrant: begin
            if (!i_req[id_q] || hold_expired) begin
               state_d = StGap;
               grant_d = '0;
               valid_d = 1'b0;
               id_d    = '0;
               ptr_d   = owner_next;
            end
         end
         StGap: begin
            if (any_req) begin
               state_d          = StGrant;
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               valid_d          = 1'b1;
               id_d             = sel_idx;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

   logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
   logic            timeout_q, timeout_d;

   // Counter reads k-1 on the k-th GRANT edge, so expiry after MAX_HOLD visible cycles.
   assign hold_expired = (hold_cnt_q == CntW'(MAX_HOLD - 1));

   always_comb begin
      hold_cnt_d = '0;
      if (state_q == StGrant && state_d == StGrant) begin
         hold_cnt_d = hold_cnt_q + CntW'(1);
      end
      timeout_d = (state_q == StGrant) && i_req[id_q] && hold_expired;
   end

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign hold_expired = 1'b0;
   assign o_timeout    = 1'b0;
`endif

   assign o_grant       = grant_q;
   assign o_grant_valid = valid_q;
   assign o_grant_id    = id_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Scoreboard bench for fsm_rr_arbiter: each grant episode is checked against a queued
// expectation (owner, length, zero gap before it, o_timeout in the following cycle).
module tb_fsm_rr_arbiter;

   logic       i_sys_clk = 1'b0;
   logic       i_rst_n   = 1'b0;
   logic [3:0] i_req     = 4'b0000;
   logic [3:0] o_grant;
   logic       o_grant_valid;
   logic [1:0] o_grant_id;
   logic       o_timeout;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] grant;
      int         id;
      int         len;  // -1: don't care
      int         gap;  // -1: don't care
      int         to;   // -1: don't care
   } exp_t;

   exp_t exp_q[$];

   fsm_rr_arbiter #(
      .N_REQ   (4),
      .MAX_HOLD(16),
      .ID_W    (2)
   ) u_dut (
      .i_sys_clk    (i_sys_clk),
      .i_rst_n      (i_rst_n),
      .i_req        (i_req),
      .o_grant      (o_grant),
      .o_grant_valid(o_grant_valid),
      .o_grant_id   (o_grant_id),
      .o_timeout    (o_timeout)
   );

   always #5 i_sys_clk = ~i_sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {24'd0, o_grant, o_grant_valid, o_grant_id, o_timeout}, 32'd0);
   endtask

   task automatic push(input logic [3:0] g, input int id, input int len, input int gap,
                       input int to);
      exp_t e;
      e.grant = g;
      e.id    = id;
      e.len   = len;
      e.gap   = gap;
      e.to    = to;
      exp_q.push_back(e);
   endtask

   // Monitor state
   logic       prev_v = 1'b0;
   int         run_len = 0;
   int         zeros = 1000;
   int         start_gap = 0;
   logic [3:0] start_grant = '0;
   logic [1:0] start_id = '0;
   bit         bad_hold = 0, bad_cons = 0, bad_to = 0;
   int         idle_bad = 0;

   task automatic end_episode(input logic to_now);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL unexpected_grant: got id %0d, expected no grant", start_id);
      end else begin
         e = exp_q.pop_front();
         check("grant_onehot", 32'(start_grant), 32'(e.grant));
         check("grant_id", 32'(start_id), 32'(e.id));
         if (e.len >= 0) check("grant_len", 32'(run_len), 32'(e.len));
         if (e.gap >= 0) check("gap_before", 32'(start_gap), 32'(e.gap));
         if (e.to >= 0) check("timeout_in_gap", 32'(to_now), 32'(e.to));
         check("grant_stable", 32'(bad_hold), 32'd0);
         check("valid_id_consistent", 32'(bad_cons), 32'd0);
         check("timeout_during_grant", 32'(bad_to), 32'd0);
      end
   endtask

   initial begin
      forever begin
         @(negedge i_sys_clk);
         if (o_grant_valid) begin
            if (!prev_v) begin
               start_grant = o_grant;
               start_id    = o_grant_id;
               start_gap   = zeros;
               run_len     = 0;
               bad_hold    = 0;
               bad_cons    = 0;
               bad_to      = 0;
            end
            run_len++;
            if (o_grant !== start_grant || o_grant_id !== start_id) bad_hold = 1;
            if (o_grant !== (4'b0001 << o_grant_id)) bad_cons = 1;
            if (o_timeout) bad_to = 1;
            zeros = 0;
         end else begin
            if (o_grant !== 4'b0000 || o_grant_id !== 2'd0) idle_bad++;
            if (prev_v) end_episode(o_timeout);
            else if (o_timeout) idle_bad++;
            zeros++;
         end
         prev_v = o_grant_valid;
      end
   end

   // Wait (bounded) for a new grant, keep it for n cycles, then drive 'after'.
   task automatic serve(input int n, input logic [3:0] after, input int max_wait,
                        input string name);
      logic prev;
      bit   got;
      prev = o_grant_valid;
      got  = 0;
      for (int k = 0; k < max_wait && !got; k++) begin
         @(negedge i_sys_clk);
         if (o_grant_valid && !prev) got = 1;
         prev = o_grant_valid;
      end
      check({name, "_grant_seen"}, 32'(got), 32'd1);
      if (got) repeat (n - 1) @(negedge i_sys_clk);
      i_req = after;
   endtask

   task automatic pulse_reset();
      @(negedge i_sys_clk);
      i_rst_n = 1'b0;
      repeat (2) @(negedge i_sys_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   held;
      int   n_started;
      int   down[4];
      bit   done;
      int   bad;

      // 1: reset with no requests, 20 idle cycles
      #1;
      check_idle("reset_outputs");
      @(negedge i_sys_clk);
      i_rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge i_sys_clk);
         if ({o_grant, o_grant_valid, o_grant_id, o_timeout} !== 8'd0) bad++;
      end
      check("idle_20_cycles", 32'(bad), 32'd0);

      // 2: single requester 2, one-edge latency, held for 5 cycles
      push(4'b0100, 2, 5, -1, 0);
      i_req = 4'b0100;
      serve(5, 4'b0000, 1, "t2");
      repeat (3) @(negedge i_sys_clk);
      check_idle("t2_back_to_idle");

      // 3: all requesting, each owner drops after 3 cycles and re-raises 2 later
      pulse_reset();
      push(4'b0001, 0, 3, -1, 0);
      push(4'b0010, 1, 3, 1, 0);
      push(4'b0100, 2, 3, 1, 0);
      push(4'b1000, 3, 3, 1, 0);
      push(4'b0001, 0, 3, 1, 0);
      i_req     = 4'b1111;
      held      = 0;
      n_started = 0;
      done      = 0;
      for (int r = 0; r < 4; r++) down[r] = 0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge i_sys_clk);
         for (int r = 0; r < 4; r++) begin
            if (down[r] > 0) begin
               down[r]--;
               if (down[r] == 0) i_req[r] = 1'b1;
            end
         end
         if (o_grant_valid) begin
            held++;
            if (held == 1) n_started++;
            if (held == 3) begin
               i_req[o_grant_id] = 1'b0;
               down[o_grant_id]  = 2;
               held              = 0;
               if (n_started == 5) begin
                  i_req = 4'b0000;
                  done  = 1;
               end
            end
         end
      end
      check("t3_five_grants_done", 32'(done), 32'd1);
      i_req = 4'b0000;
      repeat (4) @(negedge i_sys_clk);

      // 4/5: two requesters held continuously
      pulse_reset();
`ifdef ARB_TIMEOUT_EN
      push(4'b0001, 0, 16, -1, 1);
      push(4'b0010, 1, 16, 1, 1);
      push(4'b0001, 0, 6, 1, 0);
      i_req = 4'b0011;
      repeat (40) @(negedge i_sys_clk);
      i_req = 4'b0000;
`else
      push(4'b0001, 0, 200, -1, 0);
      i_req = 4'b0011;
      bad   = 0;
      repeat (200) begin
         @(negedge i_sys_clk);
         if (o_grant !== 4'b0001 || o_timeout !== 1'b0) bad++;
      end
      check("t5_hold_200_cycles", 32'(bad), 32'd0);
      i_req = 4'b0000;
`endif
      repeat (4) @(negedge i_sys_clk);

      // 6: asynchronous reset mid-grant of req2, then restart with 1010
      push(4'b0100, 2, 3, -1, 0);
      push(4'b0010, 1, 2, -1, 0);
      push(4'b1000, 3, 1, 1, 0);
      i_req = 4'b0100;
      serve(3, 4'b0100, 2, "t6_req2");
      check("t6_grant_before_reset", 32'(o_grant), 32'(4'b0100));
      #2;
      i_rst_n = 1'b0;
      i_req   = 4'b1010;
      #1;
      check_idle("t6_async_reset");
      @(negedge i_sys_clk);
      i_rst_n = 1'b1;
      serve(2, 4'b1000, 2, "t6_req1");
      serve(1, 4'b0000, 3, "t6_req3");

      repeat (5) @(negedge i_sys_clk);
      check_idle("final_idle");
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("idle_outputs_clean", 32'(idle_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
